syn_filt_sched: RTL and testbench



---
 rtl/syn_filt_sched_if.sv | 35 +++
 rtl/syn_filt_sched.sv | 164 ++++++++++++++++
 tb/tb_syn_filt_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/syn_filt_sched_if.sv
// Bus bundle between the subframe scheduler and its environment.
// Latency: none, plain wires.
// Backpressure: none on the bundle; syn_filt completion is signalled by sfDone.
interface syn_filt_sched_if;
    logic        start;
    logic        done;
    logic        busy;
    logic [31:0] memIn;
    logic [10:0] memReadAddr;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic        memOwner;
    logic        sfStart;
    logic        sfDone;
    logic [10:0] sfXAddr;
    logic [10:0] sfAAddr;
    logic [10:0] sfYAddr;
    logic [10:0] sfFMemAddr;
    logic [10:0] sfUpdateAddr;

    // scheduler side
    modport master (
        input  start, memIn, sfDone,
        output done, busy, memReadAddr, memWriteAddr, memOut, memWriteEn,
               memOwner, sfStart, sfXAddr, sfAAddr, sfYAddr, sfFMemAddr, sfUpdateAddr
    );

    // environment side: frame control, scratch memory, syn_filt
    modport slave (
        output start, memIn, sfDone,
        input  done, busy, memReadAddr, memWriteAddr, memOut, memWriteEn,
               memOwner, sfStart, sfXAddr, sfAAddr, sfYAddr, sfFMemAddr, sfUpdateAddr
    );
endinterface

// File: rtl/syn_filt_sched.sv
// Runs syn_filt over NUM_SUBFR subframes, writing update flags and carrying the last M outputs into filter memory.
// Latency: start-to-done = 1 + sum over subframes of (2 + RUN_WAIT cycles + M*(RD_LAT+1)).
// Backpressure: start ignored while busy; each subframe stalls until a fresh sfDone rising edge.
module syn_filt_sched #(
    parameter int          NUM_SUBFR  = 2,
    parameter int          L_SUBFR    = 40,
    parameter int          M          = 10,
    parameter int          RD_LAT     = 2,
    parameter logic [10:0] X_BASE     = 11'd560,
    parameter logic [10:0] A_BASE     = 11'd624,
    parameter logic [10:0] Y_BASE     = 11'd688,
    parameter logic [10:0] FMEM_BASE  = 11'd816,
    parameter logic [10:0] UPD_BASE   = 11'd944,
    parameter logic [10:0] SF_STRIDE  = 11'd1024,
    parameter logic [31:0] UPDATE_VAL = 32'd1
) (
    input  logic              clk,
    input  logic              reset,
    syn_filt_sched_if.master  bus
);
    localparam int          IW      = $clog2(M + 1);
    localparam int          KW      = (NUM_SUBFR > 1) ? $clog2(NUM_SUBFR) : 1;
    localparam int          WW      = $clog2(RD_LAT + 1);
    localparam logic [10:0] CPY_OFF = 11'(L_SUBFR - M);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_UPD, S_RUN_START, S_RUN_WAIT,
        S_CPY_RD, S_CPY_WAIT, S_CPY_WR, S_FINISH
    } state_t;

    state_t      r_state;
    logic [KW-1:0] r_k;
    logic [IW-1:0] r_i;
    logic [WW-1:0] r_wait;
    logic        r_sf_done_d;
    logic        r_done, r_busy, r_sf_start, r_we, r_owner;
    logic [31:0] r_wdat;
    logic [10:0] r_raddr, r_waddr;
    logic [10:0] r_sf_x, r_sf_a, r_sf_y, r_sf_upd;
    logic        w_sf_rise;
    logic        w_go_wr;

    // Only a fresh rising edge ends RUN_WAIT, so a level left high from the previous run is not taken as done.
    assign w_sf_rise = bus.sfDone & ~r_sf_done_d;

    // Read data is sampled RD_LAT edges after the edge that loaded memReadAddr.
    assign w_go_wr = ((r_state == S_CPY_RD) && (RD_LAT == 1)) ||
                     ((r_state == S_CPY_WAIT) && (r_wait == WW'(RD_LAT - 1)));

    // Scheduler FSM; every output register is loaded with the value of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_i         <= '0;
            r_wait      <= '0;
            r_sf_done_d <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_sf_start  <= 1'b0;
            r_we        <= 1'b0;
            r_owner     <= 1'b1;
            r_wdat      <= '0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_sf_x      <= X_BASE;
            r_sf_a      <= A_BASE;
            r_sf_y      <= Y_BASE;
            r_sf_upd    <= UPD_BASE;
        end else begin
            r_we        <= 1'b0;
            r_sf_start  <= 1'b0;
            r_done      <= 1'b0;
            r_sf_done_d <= bus.sfDone;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_WR_UPD;
                        r_busy   <= 1'b1;
                        r_k      <= '0;
                        r_sf_x   <= X_BASE;
                        r_sf_a   <= A_BASE;
                        r_sf_y   <= Y_BASE;
                        r_sf_upd <= UPD_BASE;
                        r_we     <= 1'b1;
                        r_waddr  <= UPD_BASE;
                        r_wdat   <= UPDATE_VAL;
                    end
                end
                S_WR_UPD: begin
                    r_state    <= S_RUN_START;
                    r_sf_start <= 1'b1;
                    r_owner    <= 1'b0;
                end
                S_RUN_START: begin
                    r_state <= S_RUN_WAIT;
                end
                S_RUN_WAIT: begin
                    if (w_sf_rise) begin
                        r_state <= S_CPY_RD;
                        r_owner <= 1'b1;
                        r_i     <= '0;
                        r_raddr <= r_sf_y + CPY_OFF;
                    end
                end
                S_CPY_RD: begin
                    if (RD_LAT > 1) begin
                        r_state <= S_CPY_WAIT;
                        r_wait  <= WW'(1);
                    end
                end
                S_CPY_WAIT: begin
                    r_wait <= r_wait + WW'(1);
                end
                S_CPY_WR: begin
                    if (r_i < IW'(M - 1)) begin
                        r_state <= S_CPY_RD;
                        r_i     <= r_i + IW'(1);
                        r_raddr <= r_sf_y + CPY_OFF + 11'(r_i) + 11'd1;
                    end else if (r_k < KW'(NUM_SUBFR - 1)) begin
                        r_state  <= S_WR_UPD;
                        r_k      <= r_k + KW'(1);
                        r_sf_x   <= r_sf_x + SF_STRIDE;
                        r_sf_a   <= r_sf_a + SF_STRIDE;
                        r_sf_y   <= r_sf_y + SF_STRIDE;
                        r_sf_upd <= r_sf_upd + SF_STRIDE;
                        r_we     <= 1'b1;
                        r_waddr  <= r_sf_upd + SF_STRIDE;
                        r_wdat   <= UPDATE_VAL;
                    end else begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // Entering CPY_WR overrides the CPY_RD/CPY_WAIT choices above.
            if (w_go_wr) begin
                r_state <= S_CPY_WR;
                r_we    <= 1'b1;
                r_waddr <= FMEM_BASE + 11'(r_i);
                r_wdat  <= bus.memIn;
            end
        end
    end

    assign bus.done         = r_done;
    assign bus.busy         = r_busy;
    assign bus.sfStart      = r_sf_start;
    assign bus.memWriteEn   = r_we;
    assign bus.memOwner     = r_owner;
    assign bus.memOut       = r_wdat;
    assign bus.memReadAddr  = r_raddr;
    assign bus.memWriteAddr = r_waddr;
    assign bus.sfXAddr      = r_sf_x;
    assign bus.sfAAddr      = r_sf_a;
    assign bus.sfYAddr      = r_sf_y;
    assign bus.sfFMemAddr   = FMEM_BASE;
    assign bus.sfUpdateAddr = r_sf_upd;
endmodule

// File: tb/tb_syn_filt_sched.sv
// Bench for syn_filt_sched: scratch memory model, directed syn_filt responses, scoreboarded outputs.
// Latency: expected start-to-done computed from the per-subframe formula.
// Backpressure: syn_filt done timing is varied per subframe, including stale and immediate done.
module tb_syn_filt_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    syn_filt_sched_if bus();
    syn_filt_sched dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [1:0]  kind;   // 0 write, 1 syn_filt start, 2 done
        logic [10:0] a;
        logic [63:0] d;
    } ev_t;

    ev_t         q[$];
    logic [31:0] mem [0:2047];
    int          cyc = 0;
    int          t_start = 0;
    int          checks = 0;
    int          fails = 0;

    // Scratch memory: write through scheduler port; one-stage registered read (RD_LAT = 2).
    always @(posedge clk) begin
        if (bus.memOwner && bus.memWriteEn) mem[bus.memWriteAddr] = bus.memOut;
        bus.memIn <= mem[bus.memReadAddr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] sfa(input int base, input int k);
        return 11'((base + k * 1024) % 2048);
    endfunction

    task automatic push_ev(input logic [1:0] k, input logic [10:0] a, input logic [63:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    task automatic push_start(input int k);
        push_ev(2'd1, sfa(560, k), {20'd0, sfa(624, k), sfa(688, k), sfa(944, k), 11'd816});
    endtask

    task automatic mon_pop(input logic [1:0] kind, input logic [10:0] a, input logic [63:0] d);
        ev_t e;
        if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_output: got kind %0d addr %0d data %0h, required nothing", kind, a, d);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 64'(kind), 64'(e.kind));
            chk("ev_addr", 64'(a), 64'(e.a));
            chk("ev_data", d, e.d);
        end
    endtask

    // Monitor: every write, syn_filt start and done is matched against the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.memWriteEn) begin
                chk("wr_owner", 64'(bus.memOwner), 64'd1);
                mon_pop(2'd0, bus.memWriteAddr, 64'(bus.memOut));
            end
            if (bus.sfStart)
                mon_pop(2'd1, bus.sfXAddr, {20'd0, bus.sfAAddr, bus.sfYAddr, bus.sfUpdateAddr, bus.sfFMemAddr});
            if (bus.done)
                mon_pop(2'd2, 11'd0, 64'(cyc - t_start));
        end
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_done"},   64'(bus.done), 0);
        chk({pfx, "_busy"},   64'(bus.busy), 0);
        chk({pfx, "_sfstart"},64'(bus.sfStart), 0);
        chk({pfx, "_we"},     64'(bus.memWriteEn), 0);
        chk({pfx, "_owner"},  64'(bus.memOwner), 1);
        chk({pfx, "_memout"}, 64'(bus.memOut), 0);
        chk({pfx, "_raddr"},  64'(bus.memReadAddr), 0);
        chk({pfx, "_waddr"},  64'(bus.memWriteAddr), 0);
        chk({pfx, "_xaddr"},  64'(bus.sfXAddr), 560);
        chk({pfx, "_aaddr"},  64'(bus.sfAAddr), 624);
        chk({pfx, "_yaddr"},  64'(bus.sfYAddr), 688);
        chk({pfx, "_faddr"},  64'(bus.sfFMemAddr), 816);
        chk({pfx, "_uaddr"},  64'(bus.sfUpdateAddr), 944);
    endtask

    // syn_filt stand-in: after sfStart, sfDone high for hi cycles, low for lo cycles, then a one-cycle pulse.
    task automatic sf_resp(input int hi, input int lo, input bit inj);
        int n = 0;
        while (!bus.sfStart && n < 500) begin @(negedge clk); n++; end
        if (!bus.sfStart) begin
            checks++; fails++;
            $display("FAIL sfstart_timeout: got no sfStart in %0d cycles, required one", n);
            return;
        end
        chk("own_at_sfstart", 64'(bus.memOwner), 0);
        for (int c = 0; c < hi; c++) begin @(negedge clk); bus.sfDone = 1'b1; end
        for (int c = 0; c < lo; c++) begin
            @(negedge clk);
            bus.sfDone = 1'b0;
            bus.start  = (inj && c == 2);
        end
        @(negedge clk); bus.sfDone = 1'b1; bus.start = 1'b0;
        chk("own_at_sfdone", 64'(bus.memOwner), 0);
        @(negedge clk); bus.sfDone = 1'b0;
        chk("own_after_sfdone", 64'(bus.memOwner), 1);
    endtask

    task automatic preload(input int f, output logic [31:0] b0, output logic [31:0] b1);
        b0 = 32'h100 + 32'(f) * 32'h1000;
        b1 = 32'h200 + 32'(f) * 32'h1000;
        mem[944] = 0; mem[1968] = 0;
        for (int j = 0; j < 10; j++) begin
            mem[816 + j]  = 0;
            mem[718 + j]  = b0 + 32'(j);
            mem[1742 + j] = b1 + 32'(j);
        end
    endtask

    task automatic run_frame(input int f, input int hi0, input int lo0, input int lo1, input bit inj);
        logic [31:0] b0, b1;
        int t0, t1, n;
        t0 = hi0 + lo0 + 1;
        t1 = lo1 + 1;
        preload(f, b0, b1);
        for (int k = 0; k < 2; k++) begin
            push_ev(2'd0, sfa(944, k), 64'd1);
            push_start(k);
            for (int j = 0; j < 10; j++)
                push_ev(2'd0, 11'(816 + j), 64'((k == 0 ? b0 : b1) + 32'(j)));
        end
        push_ev(2'd2, 11'd0, 64'(1 + (2 + t0 + 30) + (2 + t1 + 30)));
        if (hi0 > 0) bus.sfDone = 1'b1;
        @(negedge clk); bus.start = 1'b1; t_start = cyc;
        @(negedge clk); bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 1);
        sf_resp(hi0, lo0, inj);
        sf_resp(0, lo1, 1'b0);
        if (inj) begin
            n = 0;
            while (!bus.memWriteEn && n < 20) begin @(negedge clk); n++; end
            bus.start = 1'b1;
            @(negedge clk); bus.start = 1'b0;
        end
        n = 0;
        while (!bus.done && n < 400) begin @(negedge clk); n++; end
        if (!bus.done) begin
            checks++; fails++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a pulse", n);
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 0);
        chk("busy_after_done", 64'(bus.busy), 0);
        repeat (4) @(negedge clk);
        chk("no_second_frame", 64'(bus.busy), 0);
        chk("upd_flag_sf0", 64'(mem[944]), 1);
        chk("upd_flag_sf1", 64'(mem[1968]), 1);
        for (int j = 0; j < 10; j++) chk("fmem_final", 64'(mem[816 + j]), 64'(b1 + 32'(j)));
        chk("queue_empty", 64'(q.size()), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] b0, b1;
        bus.start = 1'b0;
        bus.sfDone = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // nominal frame: 50-cycle syn_filt, 165-cycle latency
        run_frame(0, 0, 49, 49, 1'b0);
        // start pulses during RUN_WAIT and CPY_WR are ignored
        run_frame(1, 0, 9, 6, 1'b1);
        // stale sfDone held through RUN_START
        run_frame(2, 20, 5, 3, 1'b0);

        // reset during CPY_WAIT of subframe 0
        preload(4, b0, b1);
        push_ev(2'd0, 11'd944, 64'd1);
        push_start(0);
        @(negedge clk); bus.start = 1'b1; t_start = cyc;
        @(negedge clk); bus.start = 1'b0;
        sf_resp(0, 9, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_reset_vals("rst_async");
        @(negedge clk);
        chk_reset_vals("rst_next");
        @(negedge clk);
        chk("no_partial_copy", 64'(mem[816]), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("queue_empty_rst", 64'(q.size()), 0);

        // full frame after reset, done on the first RUN_WAIT cycle
        run_frame(3, 0, 0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule
